// File: rtl/imem_program_loader.sv
// Byte-stream instruction loader: assembles little-endian words from a valid/ready stream,
// writes them to instruction memory and holds the core in reset until the load completes.
module imem_program_loader #(
  parameter int DEPTH          = 16,
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_load,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset_out,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int              TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]     DEPTH_N  = 16'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        idx_q, idx_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic              rst_out_q, rst_out_d;

  logic              accept_s;
  logic [15:0]       new_len_s;
  logic [ADDR_W:0]   words_inc_s;

  assign accept_s    = byte_valid && ready_q;
  assign new_len_s   = {byte_data, len_q[7:0]};
  assign words_inc_s = words_q + (ADDR_W+1)'(1);

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    words_d = words_q;
    done_d  = done_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_load) begin
          state_d = S_LEN0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          words_d = '0;
          idx_d   = 2'd0;
          timer_d = '0;
        end else begin
          state_d = state_q;
        end
      end
      S_LEN0: begin
        if (accept_s) begin
          len_d[7:0] = byte_data;
          timer_d    = '0;
          state_d    = S_LEN1;
        end else if (timer_q == TMR_LAST) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_LEN1: begin
        if (accept_s) begin
          len_d[15:8] = byte_data;
          timer_d     = '0;
          if ((new_len_s == 16'd0) || (new_len_s > DEPTH_N)) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end else if (timer_q == TMR_LAST) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_DATA: begin
        if (accept_s) begin
          case (idx_q)
            2'd0:    wdata_d[7:0]   = byte_data;
            2'd1:    wdata_d[15:8]  = byte_data;
            2'd2:    wdata_d[23:16] = byte_data;
            default: wdata_d[31:24] = byte_data;
          endcase
          idx_d   = idx_q + 2'd1;
          timer_d = '0;
          if (idx_q == 2'd3) begin
            state_d = S_WRITE;
            addr_d  = words_q[ADDR_W-1:0];
          end else begin
            state_d = S_DATA;
          end
        end else if (timer_q == TMR_LAST) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_WRITE: begin
        words_d = words_inc_s;
        if (16'(words_inc_s) == len_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_DATA;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d   = (state_d == S_LEN0) || (state_d == S_LEN1) || (state_d == S_DATA);
    we_d      = (state_d == S_WRITE);
    rst_out_d = !((state_d == S_IDLE) || (state_d == S_DONE));
  end

  // State and output registers; synchronous reset leaves the core held in reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      len_q     <= 16'd0;
      idx_q     <= 2'd0;
      timer_q   <= '0;
      wdata_q   <= 32'd0;
      addr_q    <= '0;
      words_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      rst_out_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      wdata_q   <= wdata_d;
      addr_q    <= addr_d;
      words_q   <= words_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      we_q      <= we_d;
      rst_out_q <= rst_out_d;
    end
  end

  assign byte_ready    = ready_q;
  assign imem_we       = we_q;
  assign imem_addr     = addr_q;
  assign imem_wdata    = wdata_q;
  assign cpu_reset_out = rst_out_q;
  assign load_done     = done_q;
  assign load_error    = err_q;
  assign words_loaded  = words_q;

  imem_program_loader_checker u_checker (
    .clock         (clock),
    .reset         (reset),
    .byte_ready    (ready_q),
    .imem_we       (we_q),
    .cpu_reset_out (rst_out_q),
    .load_done     (done_q),
    .load_error    (err_q)
  );

endmodule

// Output invariants of the loader.
module imem_program_loader_checker (
  input logic clock,
  input logic reset,
  input logic byte_ready,
  input logic imem_we,
  input logic cpu_reset_out,
  input logic load_done,
  input logic load_error
);

  a_we_in_reset:    assert property (@(posedge clock) disable iff (reset)
                      imem_we |-> (cpu_reset_out && !byte_ready));
  a_we_single:      assert property (@(posedge clock) disable iff (reset)
                      imem_we |=> !imem_we);
  a_done_xor_error: assert property (@(posedge clock) disable iff (reset)
                      !(load_done && load_error));
  a_done_released:  assert property (@(posedge clock) disable iff (reset)
                      load_done |-> !cpu_reset_out);

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench: expected memory writes go into a scoreboard queue; a monitor pops and
// compares on every imem_we strobe, while status outputs are checked inline.
module tb_imem_program_loader;

  localparam int DEPTH = 16;
  localparam int ADDR_W = 4;
  localparam int TMO = 1024;

  logic              clock;
  logic              reset;
  logic              start_load;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset_out;
  logic              load_done;
  logic              load_error;
  logic [ADDR_W:0]   words_loaded;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] mem [DEPTH];
  int          checks = 0;
  int          passed = 0;

  imem_program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clock         (clock),
    .reset         (reset),
    .start_load    (start_load),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .byte_ready    (byte_ready),
    .imem_we       (imem_we),
    .imem_addr     (imem_addr),
    .imem_wdata    (imem_wdata),
    .cpu_reset_out (cpu_reset_out),
    .load_done     (load_done),
    .load_error    (load_error),
    .words_loaded  (words_loaded)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge clock) begin
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", {31'd0, imem_we}, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {28'd0, imem_addr}, {28'd0, e.addr});
        check("wr_data", imem_wdata, e.data);
        check("wr_core_held", {31'd0, cpu_reset_out}, 32'd1);
      end
      mem[imem_addr] = imem_wdata;
    end
  end

  // All tasks start and end just after a falling edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) begin
      check("ready_wait", {31'd0, byte_ready}, 32'd1);
      byte_valid = 1'b0;
    end else begin
      @(posedge clock);
      @(negedge clock);
      byte_valid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int addr, input bit gaps);
    exp_q.push_back('{addr: addr[ADDR_W-1:0], data: w});
    for (int k = 0; k < 4; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clock);
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic pulse_start();
    start_load = 1'b1;
    @(negedge clock);
    start_load = 1'b0;
  endtask

  function automatic logic [31:0] w4(input int i);
    return 32'h0000_0013 | (32'(i) << 20) | (32'(i) << 7);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start_load = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hDEAD_BEEF;
    repeat (3) @(negedge clock);
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_addr", {28'd0, imem_addr}, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_cpu", {31'd0, cpu_reset_out}, 32'd1);
    check("rst_done", {31'd0, load_done}, 32'd0);
    check("rst_err", {31'd0, load_error}, 32'd0);
    check("rst_words", {27'd0, words_loaded}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_cpu", {31'd0, cpu_reset_out}, 32'd0);

    // 1: two-word program
    pulse_start();
    check("t1_len0_ready", {31'd0, byte_ready}, 32'd1);
    check("t1_len0_cpu", {31'd0, cpu_reset_out}, 32'd1);
    send_byte(8'h02); send_byte(8'h00);
    send_word(32'h00A0_0093, 0, 1'b0);
    send_word(32'h00B0_0113, 1, 1'b0);
    check("t1_done_latency", {31'd0, load_done}, 32'd0);
    @(negedge clock);
    check("t1_done", {31'd0, load_done}, 32'd1);
    check("t1_words", {27'd0, words_loaded}, 32'd2);
    check("t1_cpu_released", {31'd0, cpu_reset_out}, 32'd0);
    check("t1_ready_off", {31'd0, byte_ready}, 32'd0);

    // 2: illegal lengths
    pulse_start();
    check("t2_done_cleared", {31'd0, load_done}, 32'd0);
    check("t2_words_cleared", {27'd0, words_loaded}, 32'd0);
    send_byte(8'h00); send_byte(8'h00);
    check("t2_len0_err", {31'd0, load_error}, 32'd1);
    check("t2_len0_ready", {31'd0, byte_ready}, 32'd0);
    check("t2_len0_cpu", {31'd0, cpu_reset_out}, 32'd1);
    pulse_start();
    check("t2_err_cleared", {31'd0, load_error}, 32'd0);
    send_byte(8'h11); send_byte(8'h00);
    check("t2_len17_err", {31'd0, load_error}, 32'd1);

    // 3: timeout, with a byte landing on the last allowed cycle
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    repeat (TMO - 1) @(negedge clock);
    check("t3_no_err_at_limit", {31'd0, load_error}, 32'd0);
    send_byte(8'h33);
    check("t3_byte_wins", {31'd0, load_error}, 32'd0);
    repeat (TMO - 1) @(negedge clock);
    check("t3_pre_limit", {31'd0, load_error}, 32'd0);
    check("t3_pre_limit_ready", {31'd0, byte_ready}, 32'd1);
    @(negedge clock);
    check("t3_timeout_err", {31'd0, load_error}, 32'd1);
    check("t3_timeout_ready", {31'd0, byte_ready}, 32'd0);
    check("t3_timeout_cpu", {31'd0, cpu_reset_out}, 32'd1);

    // 4: full-depth load with irregular byte_valid
    pulse_start();
    send_byte(8'h10); send_byte(8'h00);
    for (int i = 0; i < DEPTH; i++) send_word(w4(i), i, 1'b1);
    @(negedge clock);
    check("t4_done", {31'd0, load_done}, 32'd1);
    check("t4_words", {27'd0, words_loaded}, 32'd16);
    check("t4_mem15", mem[15], w4(15));

    // 5: reset in the middle of the second word
    pulse_start();
    send_byte(8'h03); send_byte(8'h00);
    send_word(32'hCAFE_0001, 0, 1'b0);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    reset = 1'b1;
    @(negedge clock);
    check("t5_rst_cpu", {31'd0, cpu_reset_out}, 32'd1);
    check("t5_rst_ready", {31'd0, byte_ready}, 32'd0);
    check("t5_rst_words", {27'd0, words_loaded}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("t5_idle_cpu", {31'd0, cpu_reset_out}, 32'd0);
    check("t5_idle_ready", {31'd0, byte_ready}, 32'd0);
    check("t5_mem0", mem[0], 32'hCAFE_0001);
    check("t5_mem1_kept", mem[1], w4(1));

    // 6: start_load ignored mid-load, honoured in DONE; extra bytes refused
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    exp_q.push_back('{addr: 4'd0, data: 32'h4433_2211});
    send_byte(8'h11); send_byte(8'h22);
    pulse_start();
    check("t6_ignored_ready", {31'd0, byte_ready}, 32'd1);
    send_byte(8'h33); send_byte(8'h44);
    @(negedge clock);
    check("t6_done", {31'd0, load_done}, 32'd1);
    byte_valid = 1'b1; byte_data = 8'hFF;
    repeat (3) begin
      @(negedge clock);
      check("t6_extra_refused", {31'd0, byte_ready}, 32'd0);
    end
    byte_valid = 1'b0;
    check("t6_words_held", {27'd0, words_loaded}, 32'd1);
    pulse_start();
    check("t6_restart_done", {31'd0, load_done}, 32'd0);
    check("t6_restart_words", {27'd0, words_loaded}, 32'd0);
    check("t6_restart_cpu", {31'd0, cpu_reset_out}, 32'd1);
    send_byte(8'h01); send_byte(8'h00);
    send_word(32'h0000_006F, 0, 1'b0);
    @(negedge clock);
    check("t6_reload_done", {31'd0, load_done}, 32'd1);

    repeat (4) @(negedge clock);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
